// File: rtl/source_streamer_pkg.sv
// Shared types and character constants for the assembler text streamer.
// Line classification lives here so the top and the line tracker agree on it.
package source_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE_ASM,
    PC_MAPPING,
    ASSEMBLING
  } assembler_state_t;

  typedef enum logic [1:0] {
    LINE_BLANK,
    LINE_INSTR,
    LINE_OTHER
  } line_kind_t;

  localparam logic [7:0] CHAR_NL    = 8'h0A;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_NUL   = 8'h00;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_TAB   = 8'h09;

  function automatic logic is_alpha(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

endpackage

// File: rtl/source_streamer_line_tracker.sv
// Classifies each line by its first non-blank character and owns the byte pc.
// pc advances by 4 when an instruction line ends.
module source_streamer_line_tracker
  import source_streamer_pkg::*;
#(
  parameter int  NUMBER_LINES = 256,
  localparam int PC_W         = $clog2(NUMBER_LINES) + 2
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [7:0]      char,
  input  logic            char_valid,
  input  logic            line_end,
  input  logic            pass_restart,
  output logic [PC_W-1:0] pc,
  output logic            overflow
);

  localparam logic [PC_W-1:0] PC_LAST = PC_W'(NUMBER_LINES * 4 - 4);

  line_kind_t kind;
  logic       full;
  logic       is_blank_char;

  assign is_blank_char = (char == CHAR_SPACE) || (char == CHAR_TAB);

  // A line ending at the last pc marks the table full; a further instruction line has no pc left.
  assign overflow = line_end && (kind == LINE_INSTR) && full;

  // NOTE: registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in || pass_restart) begin
      pc   <= '0;
      kind <= LINE_BLANK;
      full <= 1'b0;
    end else if (line_end) begin
      kind <= LINE_BLANK;
      if ((kind == LINE_INSTR) && !full) begin
        if (pc == PC_LAST) begin
          full <= 1'b1;
        end else begin
          pc <= pc + PC_W'(4);
        end
      end
    end else if (char_valid && (kind == LINE_BLANK) && !is_blank_char) begin
      kind <= is_alpha(char) ? LINE_INSTR : LINE_OTHER;
    end
  end

endmodule

// File: rtl/source_streamer.sv
// Streams NUL-terminated assembly text from a byte BRAM, one character per handshake,
// twice: a PC_MAPPING pass followed by an ASSEMBLING pass.
module source_streamer
  import source_streamer_pkg::*;
#(
  parameter int  NUMBER_LINES = 256,
  parameter int  TEXT_DEPTH   = 4096,
  parameter int  BRAM_LATENCY = 2,
  localparam int ADDR_W       = $clog2(TEXT_DEPTH),
  localparam int PC_W         = $clog2(NUMBER_LINES) + 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic              hold_in,
  input  logic              error_in,
  output logic [ADDR_W-1:0] text_addr,
  input  logic [7:0]        text_data,
  output logic              valid_data,
  output logic              new_character,
  output logic [7:0]        character_out,
  output logic              new_line,
  output logic [PC_W-1:0]   pc,
  output assembler_state_t  assembler_state,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int WAIT_W = (BRAM_LATENCY > 1) ? $clog2(BRAM_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BRAM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EMIT, S_GAP, S_NEWLINE, S_PASS_END, S_DONE, S_ERROR
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              streaming;
  logic              byte_end;
  logic              start_ok;
  logic              line_end;
  logic              char_valid;
  logic              pass_restart;
  logic              overflow;
  logic              go_error;

  assign streaming    = state inside {S_FETCH, S_EMIT, S_GAP, S_NEWLINE, S_PASS_END};
  // The last BRAM byte doubles as a terminator so the address never wraps.
  assign byte_end     = (text_data == CHAR_NUL) || (text_addr == ADDR_W'(TEXT_DEPTH - 1));
  assign start_ok     = start_in && !hold_in && ((state == S_IDLE) || (state == S_DONE));
  assign line_end     = ((state == S_NEWLINE) || (state == S_PASS_END)) && !hold_in && !error_in;
  assign char_valid   = (state == S_EMIT) && !hold_in && !error_in;
  assign pass_restart = start_ok ||
                        ((state == S_PASS_END) && (assembler_state == PC_MAPPING) && !hold_in && !error_in);
  assign go_error     = streaming && (error_in || overflow);

  source_streamer_line_tracker #(
    .NUMBER_LINES(NUMBER_LINES)
  ) u_line_tracker (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .char        (character_out),
    .char_valid  (char_valid),
    .line_end    (line_end),
    .pass_restart(pass_restart),
    .pc          (pc),
    .overflow    (overflow)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= S_IDLE;
      wait_cnt        <= '0;
      text_addr       <= '0;
      character_out   <= '0;
      valid_data      <= 1'b0;
      new_character   <= 1'b0;
      new_line        <= 1'b0;
      assembler_state <= IDLE_ASM;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
    end else if (go_error) begin
      state           <= S_ERROR;
      valid_data      <= 1'b0;
      new_character   <= 1'b0;
      new_line        <= 1'b0;
      assembler_state <= IDLE_ASM;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b1;
    end else if (!hold_in) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state           <= S_FETCH;
            wait_cnt        <= '0;
            text_addr       <= '0;
            valid_data      <= 1'b1;
            assembler_state <= PC_MAPPING;
            busy            <= 1'b1;
          end
        end
        S_FETCH: begin
          // text_data is sampled on the BRAM_LATENCY-th edge after text_addr changes.
          if (wait_cnt != WAIT_LAST) begin
            wait_cnt <= wait_cnt + 1'b1;
          end else begin
            wait_cnt <= '0;
            if (byte_end) begin
              state      <= S_PASS_END;
              valid_data <= 1'b0;
              done       <= (assembler_state == ASSEMBLING);
            end else if (text_data == CHAR_NL) begin
              state    <= S_NEWLINE;
              new_line <= 1'b1;
            end else if (text_data == CHAR_CR) begin
              text_addr <= text_addr + 1'b1;
            end else begin
              state         <= S_EMIT;
              new_character <= 1'b1;
              character_out <= text_data;
            end
          end
        end
        S_EMIT: begin
          state         <= S_GAP;
          new_character <= 1'b0;
        end
        S_GAP: begin
          state     <= S_FETCH;
          text_addr <= text_addr + 1'b1;
        end
        S_NEWLINE: begin
          state     <= S_FETCH;
          new_line  <= 1'b0;
          text_addr <= text_addr + 1'b1;
        end
        S_PASS_END: begin
          done <= 1'b0;
          if (assembler_state == PC_MAPPING) begin
            state           <= S_FETCH;
            text_addr       <= '0;
            valid_data      <= 1'b1;
            assembler_state <= ASSEMBLING;
          end else begin
            state           <= S_DONE;
            assembler_state <= IDLE_ASM;
            busy            <= 1'b0;
          end
        end
        S_ERROR: begin
        end
      endcase
    end
  end

endmodule
